// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch/load/store requesters, the port
// arbiter and the single cache request port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32
) ();
  // Instruction fetch requester
  logic                   i_req;
  logic [ADDR_WIDTH-1:0]  i_addr;
  logic                   i_ack;
  logic [INSTR_WIDTH-1:0] i_data;
  // Data load requester
  logic                   dr_req;
  logic [ADDR_WIDTH-1:0]  dr_addr;
  logic [3:0]             dr_size;
  logic                   dr_ack;
  logic [DATA_WIDTH-1:0]  dr_data;
  // Data store requester
  logic                   dw_req;
  logic [ADDR_WIDTH-1:0]  dw_addr;
  logic [DATA_WIDTH-1:0]  dw_data;
  logic [3:0]             dw_size;
  logic                   dw_ack;
  // Cache port
  logic                   c_read;
  logic                   c_write;
  logic [ADDR_WIDTH-1:0]  c_addr;
  logic [DATA_WIDTH-1:0]  c_wdata;
  logic [3:0]             c_size;
  logic                   c_busy;
  logic [DATA_WIDTH-1:0]  c_rdata;
  // Current owner: 0 none, 1 fetch, 2 load, 3 store
  logic [1:0]             grant_id;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, dr_req, dr_addr, dr_size, dw_req, dw_addr, dw_data, dw_size,
           c_busy, c_rdata,
    output i_ack, i_data, dr_ack, dr_data, dw_ack, c_read, c_write, c_addr, c_wdata, c_size,
           grant_id
  );

  // Requesters and cache side
  modport master (
    output i_req, i_addr, dr_req, dr_addr, dr_size, dw_req, dw_addr, dw_data, dw_size,
           c_busy, c_rdata,
    input  i_ack, i_data, dr_ack, dr_data, dw_ack, c_read, c_write, c_addr, c_wdata, c_size,
           grant_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single cache request port between instruction fetch, data load
// and data store. One request is latched at a time; the cache busy handshake
// is waited out and the owner gets a one-cycle acknowledge.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned StarveWidth = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveWidth-1:0] StarveMax = StarveWidth'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  typedef enum logic [1:0] {
    GrantNone  = 2'd0,
    GrantFetch = 2'd1,
    GrantLoad  = 2'd2,
    GrantStore = 2'd3
  } grant_e;

  state_e                  state_q, state_d;
  grant_e                  grant_q, grant_d;
  grant_e                  win;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              size_q, size_d;
  logic [StarveWidth-1:0]  starve_q, starve_d;
  logic [INSTR_WIDTH-1:0]  i_data_q, i_data_d;
  logic [DATA_WIDTH-1:0]   dr_data_q, dr_data_d;

  // Winner selection: store > load > fetch, unless fetch has waited out the starve limit.
  always_comb begin
    win = GrantNone;
    if (bus.i_req && (starve_q == StarveMax)) begin
      win = GrantFetch;
    end else if (bus.dw_req) begin
      win = GrantStore;
    end else if (bus.dr_req) begin
      win = GrantLoad;
    end else if (bus.i_req) begin
      win = GrantFetch;
    end
  end

  // Next-state logic: arbitration, operand latching, busy handshake, response capture.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    starve_d  = starve_q;
    i_data_d  = i_data_q;
    dr_data_d = dr_data_q;

    unique case (state_q)
      StIdle: begin
        // Any data grant here with i_req high is one more cycle fetch was passed over.
        if (!bus.i_req || (win == GrantFetch)) begin
          starve_d = '0;
        end else if ((win != GrantNone) && (starve_q != StarveMax)) begin
          starve_d = starve_q + StarveWidth'(1);
        end

        case (win)
          GrantFetch: begin
            addr_d  = bus.i_addr;
            wdata_d = '0;
            size_d  = 4'd4;
          end
          GrantLoad: begin
            addr_d  = bus.dr_addr;
            wdata_d = '0;
            size_d  = bus.dr_size;
          end
          GrantStore: begin
            addr_d  = bus.dw_addr;
            wdata_d = bus.dw_data;
            size_d  = bus.dw_size;
          end
          default: ;
        endcase

        if (win != GrantNone) begin
          grant_d = win;
          state_d = StIssue;
        end
      end

      StIssue: begin
        if (bus.c_busy) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (!bus.c_busy) begin
          state_d = StDone;
          if (grant_q == GrantLoad) begin
            dr_data_d = bus.c_rdata;
          end else if (grant_q == GrantFetch) begin
            i_data_d = bus.c_rdata[INSTR_WIDTH-1:0];
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        grant_d = GrantNone;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= GrantNone;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      starve_q  <= '0;
      i_data_q  <= '0;
      dr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      starve_q  <= starve_d;
      i_data_q  <= i_data_d;
      dr_data_q <= dr_data_d;
    end
  end

  // Outputs: strobes only in ISSUE, acks only in DONE, cache operands held from the latches.
  always_comb begin
    bus.c_read   = (state_q == StIssue) &&
                   ((grant_q == GrantFetch) || (grant_q == GrantLoad));
    bus.c_write  = (state_q == StIssue) && (grant_q == GrantStore);
    bus.c_addr   = addr_q;
    bus.c_wdata  = wdata_q;
    bus.c_size   = size_q;
    bus.i_ack    = (state_q == StDone) && (grant_q == GrantFetch);
    bus.dr_ack   = (state_q == StDone) && (grant_q == GrantLoad);
    bus.dw_ack   = (state_q == StDone) && (grant_q == GrantStore);
    bus.i_data   = i_data_q;
    bus.dr_data  = dr_data_q;
    bus.grant_id = grant_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected cache
// transactions and acks; the monitor doubles as the cache model, pops and
// compares whenever the DUT strobes the cache or acknowledges a requester.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 32;
  localparam int unsigned SL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INSTR_WIDTH(IW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .INSTR_WIDTH (IW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic          write;
    logic [1:0]    grant;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    size;
    logic [DW-1:0] rdata;
    int            accept_delay;
    int            busy_len;
  } cache_txn_t;

  typedef struct {
    logic [1:0]    kind;
    logic [DW-1:0] data;
  } ack_t;

  cache_txn_t cache_q[$];
  ack_t       ack_q[$];

  int compared   = 0;
  int mismatched = 0;
  int timeouts   = 0;
  int zero_req   = 0;
  bit stim_done  = 1'b0;
  bit cache_idle = 1'b1;

  // Requester behaviour on ack: keep req high, and optionally move dr_addr on.
  bit            i_keep, dr_keep, dw_keep, dr_next_en;
  logic [AW-1:0] dr_next_addr;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cache(input logic write, input logic [1:0] grant, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [3:0] size,
                            input logic [DW-1:0] rdata, input int accept_delay,
                            input int busy_len);
    cache_txn_t t;
    t.write = write; t.grant = grant; t.addr = addr; t.wdata = wdata; t.size = size;
    t.rdata = rdata; t.accept_delay = accept_delay; t.busy_len = busy_len;
    cache_q.push_back(t);
  endtask

  task automatic push_ack(input logic [1:0] kind, input logic [DW-1:0] data);
    ack_t a;
    a.kind = kind; a.data = data;
    ack_q.push_back(a);
  endtask

  task automatic drop_all();
    bus.i_req  = 1'b0;
    bus.dr_req = 1'b0;
    bus.dw_req = 1'b0;
  endtask

  // Behaves as the requesters: each drops its req on its own ack unless told to
  // keep it, and everything is released on the final expected ack.
  task automatic run_until(input int target, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.i_ack || bus.dr_ack || bus.dw_ack) begin
        seen++;
        if (seen == target) begin
          drop_all();
        end else begin
          if (bus.i_ack && !i_keep) bus.i_req = 1'b0;
          if (bus.dr_ack && !dr_keep) bus.dr_req = 1'b0;
          if (bus.dw_ack && !dw_keep) bus.dw_req = 1'b0;
          if (bus.dr_ack && dr_keep && dr_next_en) bus.dr_addr = dr_next_addr;
        end
      end
    end
    if (seen < target) begin
      timeouts++;
      $display("FAIL run_until: saw %0d acks, required %0d", seen, target);
      drop_all();
    end
    i_keep = 1'b0; dr_keep = 1'b0; dw_keep = 1'b0; dr_next_en = 1'b0;
  endtask

  // Stimulus
  initial begin : stim
    int n;
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.dr_req = 1'b0; bus.dr_addr = '0; bus.dr_size = '0;
    bus.dw_req = 1'b0; bus.dw_addr = '0; bus.dw_data = '0; bus.dw_size = '0;
    i_keep = 1'b0; dr_keep = 1'b0; dw_keep = 1'b0; dr_next_en = 1'b0; dr_next_addr = '0;

    repeat (2) @(posedge clk);
    #1 zero_req++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single fetch, 3-cycle busy
    push_cache(1'b0, 2'd1, 64'h1000, 64'h0, 4'd4, 64'h0000_0013, 0, 3);
    push_ack(2'd1, 64'h13);
    bus.i_addr = 64'h1000; bus.i_req = 1'b1;
    run_until(1, 40);

    // Three-way collision: store, then load, then fetch
    push_cache(1'b1, 2'd3, 64'h2000, 64'hAB, 4'd8, 64'h0, 0, 1);
    push_cache(1'b0, 2'd2, 64'h2100, 64'h0, 4'd8, 64'h1111_2222_3333_4444, 1, 2);
    push_cache(1'b0, 2'd1, 64'h1004, 64'h0, 4'd4, 64'hCAFE_0000_8765_4321, 0, 1);
    push_ack(2'd3, 64'h0);
    push_ack(2'd2, 64'h1111_2222_3333_4444);
    push_ack(2'd1, 64'h8765_4321);
    bus.dw_addr = 64'h2000; bus.dw_data = 64'hAB; bus.dw_size = 4'd8;
    bus.dr_addr = 64'h2100; bus.dr_size = 4'd8;
    bus.i_addr = 64'h1004;
    bus.dw_req = 1'b1; bus.dr_req = 1'b1; bus.i_req = 1'b1;
    run_until(3, 80);

    // Starvation: four stores, then fetch; the counter must restart for the next round
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 4; s++) begin
        push_cache(1'b1, 2'd3, 64'h2008, 64'h55, 4'd4, 64'h0, 0, 1);
        push_ack(2'd3, 64'h0);
      end
      push_cache(1'b0, 2'd1, 64'h1008, 64'h0, 4'd4, (r == 0) ? 64'h73 : 64'h6F, 0, 1);
      push_ack(2'd1, (r == 0) ? 64'h73 : 64'h6F);
    end
    bus.dw_addr = 64'h2008; bus.dw_data = 64'h55; bus.dw_size = 4'd4;
    bus.dr_addr = 64'h2200; bus.dr_size = 4'd2;
    bus.i_addr = 64'h1008;
    i_keep = 1'b1; dr_keep = 1'b1; dw_keep = 1'b1;
    bus.dw_req = 1'b1; bus.dr_req = 1'b1; bus.i_req = 1'b1;
    run_until(10, 200);

    // Stalled acceptance: strobe held 5 extra cycles before busy rises
    push_cache(1'b0, 2'd2, 64'h4000, 64'h0, 4'd8, 64'h0123_4567_89AB_CDEF, 5, 2);
    push_ack(2'd2, 64'h0123_4567_89AB_CDEF);
    bus.dr_addr = 64'h4000; bus.dr_size = 4'd8; bus.dr_req = 1'b1;
    run_until(1, 50);

    // Load held through its ack with a new address presented in the ack cycle
    push_cache(1'b0, 2'd2, 64'h3000, 64'h0, 4'd4, 64'hAAAA_0001, 0, 1);
    push_cache(1'b0, 2'd2, 64'h3008, 64'h0, 4'd4, 64'hBBBB_0002, 0, 1);
    push_ack(2'd2, 64'hAAAA_0001);
    push_ack(2'd2, 64'hBBBB_0002);
    bus.dr_addr = 64'h3000; bus.dr_size = 4'd4;
    dr_keep = 1'b1; dr_next_en = 1'b1; dr_next_addr = 64'h3008;
    bus.dr_req = 1'b1;
    run_until(2, 60);

    // Reset while a load sits in WAIT: no ack may follow
    push_cache(1'b0, 2'd2, 64'h5000, 64'h0, 4'd8, 64'h5A5A, 0, 6);
    bus.dr_addr = 64'h5000; bus.dr_size = 4'd8; bus.dr_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.c_read && n < 20);
    if (!bus.c_read) begin
      timeouts++;
      $display("FAIL wait_strobe: c_read got 0, expected 1");
    end
    @(negedge clk);
    reset = 1'b1;
    bus.dr_req = 1'b0;
    @(posedge clk);
    #1 zero_req++;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!cache_idle && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cache_idle) begin
      timeouts++;
      $display("FAIL cache_drain: idle got 0, expected 1");
    end
    @(negedge clk);

    // A new load after reset completes normally
    push_cache(1'b0, 2'd2, 64'h5008, 64'h0, 4'd8, 64'h7777_8888, 0, 1);
    push_ack(2'd2, 64'h7777_8888);
    bus.dr_addr = 64'h5008; bus.dr_req = 1'b1;
    run_until(1, 40);

    repeat (5) @(negedge clk);
    stim_done = 1'b1;
  end

  // Monitor and cache model: sole driver of c_busy/c_rdata, sole owner of the counters.
  cache_txn_t cur;
  int         cs;          // 0 idle, 1 stalling acceptance, 2 busy
  int         stall_left, busy_left, strobe_cnt, cyc, last_ack, zero_done;
  bit         grant_chk;

  initial begin : monitor
    logic [1:0] kind;
    ack_t       exp;
    bus.c_busy = 1'b0;
    bus.c_rdata = '0;
    cs = 0; cyc = 0; last_ack = -100; zero_done = 0; grant_chk = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;

      if (stim_done) begin
        chk("queues_empty", {32'(cache_q.size()), 32'(ack_q.size())}, '0);
        chk("timeouts", 256'(timeouts), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
      end

      if (zero_req != zero_done) begin
        zero_done = zero_req;
        chk("reset_outputs", {bus.i_ack, bus.i_data, bus.dr_ack, bus.dr_data, bus.dw_ack,
                              bus.c_read, bus.c_write, bus.c_addr, bus.c_wdata, bus.c_size,
                              bus.grant_id}, '0);
      end

      // Cache side
      if (bus.c_read === 1'b1 || bus.c_write === 1'b1) begin
        chk("strobe_excl", 256'(bus.c_read & bus.c_write), '0);
        if (cs == 0) begin
          if (cache_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL strobe_unexpected: got addr %0h, expected no strobe", bus.c_addr);
          end else begin
            cur = cache_q.pop_front();
            chk("strobe", {bus.c_write, bus.grant_id, bus.c_addr, bus.c_wdata, bus.c_size},
                {cur.write, cur.grant, cur.addr, cur.wdata, cur.size});
            strobe_cnt = 1;
            stall_left = cur.accept_delay;
            if (stall_left == 0) begin
              bus.c_busy = 1'b1; busy_left = cur.busy_len; cs = 2;
            end else begin
              cs = 1;
            end
          end
        end else if (cs == 1) begin
          strobe_cnt++;
          stall_left--;
          if (stall_left == 0) begin
            chk("strobe_len", 256'(strobe_cnt), 256'(cur.accept_delay + 1));
            bus.c_busy = 1'b1; busy_left = cur.busy_len; cs = 2;
          end
        end else begin
          compared++; mismatched++;
          $display("FAIL strobe_in_wait: got strobe, expected none while busy");
        end
      end else if (cs == 1) begin
        compared++; mismatched++;
        $display("FAIL strobe_len: got %0d, expected %0d", strobe_cnt, cur.accept_delay + 1);
        cs = 0;
      end else if (cs == 2) begin
        busy_left--;
        if (busy_left <= 0) begin
          bus.c_busy = 1'b0; bus.c_rdata = cur.rdata; cs = 0;
        end
      end
      cache_idle = (cs == 0);

      // Requester side
      if ((bus.i_ack === 1'b1) || (bus.dr_ack === 1'b1) || (bus.dw_ack === 1'b1)) begin
        chk("ack_onehot", 256'($countones({bus.i_ack, bus.dr_ack, bus.dw_ack})), 256'(1));
        chk("ack_gap", 256'(cyc - last_ack >= 4), 256'(1));
        last_ack = cyc;
        kind = bus.dw_ack ? 2'd3 : (bus.dr_ack ? 2'd2 : 2'd1);
        if (ack_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL ack_unexpected: got kind %0d, expected no ack", kind);
        end else begin
          exp = ack_q.pop_front();
          chk("ack_kind", 256'(kind), 256'(exp.kind));
          if (kind == 2'd2) chk("dr_data", 256'(bus.dr_data), 256'(exp.data));
          if (kind == 2'd1) chk("i_data", 256'(bus.i_data), 256'(exp.data[IW-1:0]));
        end
        grant_chk = 1'b1;
      end else if (grant_chk) begin
        grant_chk = 1'b0;
        chk("grant_idle", 256'(bus.grant_id), '0);
      end
    end
  end

endmodule
